// File: rtl/fetch_control_32.sv
// Instruction-fetch sequencer. It drives the external PC register's controls,
// requests instruction words, and holds the fetched word for decode.
module fetch_control_32 #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] PC,
  output logic        PCWrite,
  output logic        PCIncrement,
  output logic [31:0] PCD,
  output logic        MemRead,
  output logic [31:0] MemAddr,
  input  logic        MemReady,
  input  logic [31:0] MemData,
  input  logic        Branch,
  input  logic [31:0] BranchTarget,
  output logic [31:0] IR,
  output logic        IRValid,
  input  logic        IRAccept,
  output logic [31:0] FetchCount
);

  typedef enum logic [1:0] {
    LOAD_VEC = 2'd0,
    FETCH    = 2'd1,
    HOLD     = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        ir_valid_q, ir_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic        pc_write, pc_increment, mem_read;
  logic [31:0] pc_d_val;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d       = state_q;
    ir_d          = ir_q;
    ir_valid_d    = ir_valid_q;
    fetch_count_d = fetch_count_q;
    pc_write      = 1'b0;
    pc_increment  = 1'b0;
    mem_read      = 1'b0;
    pc_d_val      = BranchTarget;

    unique case (state_q)
      LOAD_VEC: begin
        pc_write = 1'b1;
        pc_d_val = RESET_VECTOR;
        state_d  = FETCH;
      end
      FETCH: begin
        mem_read = 1'b1;
        if (Branch) begin
          // Redirect wins over returning data: the wrong-path word is dropped.
          pc_write = 1'b1;
        end else if (MemReady) begin
          ir_d         = MemData;
          ir_valid_d   = 1'b1;
          pc_write     = 1'b1;
          pc_increment = 1'b1;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (IRAccept) begin
          ir_valid_d    = 1'b0;
          fetch_count_d = fetch_count_q + 32'd1;
        end
        if (Branch) begin
          pc_write   = 1'b1;
          ir_valid_d = 1'b0;
        end
        if (IRAccept || Branch) state_d = FETCH;
      end
      default: state_d = LOAD_VEC;
    endcase
  end

  // While reset is held the PC register must not be disturbed by stale controls.
  assign PCWrite     = Reset ? 1'b0  : pc_write;
  assign PCIncrement = Reset ? 1'b0  : pc_increment;
  assign PCD         = Reset ? 32'd0 : pc_d_val;
  assign MemRead     = Reset ? 1'b0  : mem_read;
  assign MemAddr     = PC;

  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (Reset) begin
      state_q       <= LOAD_VEC;
      ir_q          <= 32'd0;
      ir_valid_q    <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      ir_valid_q    <= ir_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign IR         = ir_q;
  assign IRValid    = ir_valid_q;
  assign FetchCount = fetch_count_q;

endmodule

// File: tb/tb_fetch_control_32.sv
// Directed bench for fetch_control_32 with a behavioural PC register and a
// zero-latency instruction memory returning addr ^ 32'hA5A5_0000.
module tb_fetch_control_32;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] PC;
  logic        PCWrite, PCIncrement, MemRead;
  logic [31:0] PCD, MemAddr, MemData, IR, FetchCount;
  logic        MemReady, Branch, IRAccept, IRValid;
  logic [31:0] BranchTarget;

  int checks   = 0;
  int failures = 0;

  fetch_control_32 #(.RESET_VECTOR(RV)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .PC          (PC),
    .PCWrite     (PCWrite),
    .PCIncrement (PCIncrement),
    .PCD         (PCD),
    .MemRead     (MemRead),
    .MemAddr     (MemAddr),
    .MemReady    (MemReady),
    .MemData     (MemData),
    .Branch      (Branch),
    .BranchTarget(BranchTarget),
    .IR          (IR),
    .IRValid     (IRValid),
    .IRAccept    (IRAccept),
    .FetchCount  (FetchCount)
  );

  always #5 Clock = ~Clock;

  // External PC register: no reset, Write/Increment/D controls.
  always @(posedge Clock)
    if (PCWrite) PC <= PCIncrement ? PC + 32'd1 : PCD;

  assign MemData = MemAddr ^ 32'hA5A5_0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset = 1'b1; MemReady = 1'b0; Branch = 1'b0; IRAccept = 1'b0;
    BranchTarget = 32'd0;

    // Reset held two cycles; comb outputs forced low.
    step();
    step();
    check("rst_pcwrite", {31'd0, PCWrite}, 32'd0);
    check("rst_memread", {31'd0, MemRead}, 32'd0);
    check("rst_pcd", PCD, 32'd0);
    check("rst_irvalid", {31'd0, IRValid}, 32'd0);
    check("rst_ir", IR, 32'd0);
    check("rst_count", FetchCount, 32'd0);

    // LOAD_VEC cycle.
    Reset = 1'b0;
    #1;
    check("lv_pcwrite", {31'd0, PCWrite}, 32'd1);
    check("lv_pcinc", {31'd0, PCIncrement}, 32'd0);
    check("lv_pcd", PCD, RV);
    check("lv_memread", {31'd0, MemRead}, 32'd0);
    step();
    check("boot_memread", {31'd0, MemRead}, 32'd1);
    check("boot_addr", MemAddr, 32'h100);
    check("boot_irvalid", {31'd0, IRValid}, 32'd0);

    // Straight-line fetch, zero wait, decode always accepting.
    MemReady = 1'b1; IRAccept = 1'b1;
    #1;
    check("sl_pcinc", {31'd0, PCIncrement}, 32'd1);
    step();
    check("sl_ir0", IR, 32'hA5A5_0100);
    check("sl_valid0", {31'd0, IRValid}, 32'd1);
    check("sl_pc0", PC, 32'h101);
    check("sl_hold_memread", {31'd0, MemRead}, 32'd0);
    step();
    check("sl_cnt1", FetchCount, 32'd1);
    check("sl_fetch_valid", {31'd0, IRValid}, 32'd0);
    step();
    check("sl_ir1", IR, 32'hA5A5_0101);
    step();
    check("sl_cnt2", FetchCount, 32'd2);
    step();
    check("sl_ir2", IR, 32'hA5A5_0102);
    step();
    check("sl_cnt3", FetchCount, 32'd3);
    check("sl_pc3", PC, 32'h103);

    // Memory wait states: three idle cycles, ready on the fourth.
    MemReady = 1'b0; IRAccept = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ws_memread", {31'd0, MemRead}, 32'd1);
      check("ws_addr", MemAddr, 32'h103);
      check("ws_pcwrite", {31'd0, PCWrite}, 32'd0);
      step();
    end
    MemReady = 1'b1;
    #1;
    check("ws_memread4", {31'd0, MemRead}, 32'd1);
    check("ws_pcwrite4", {31'd0, PCWrite}, 32'd1);
    step();
    MemReady = 1'b0;
    check("ws_pc", PC, 32'h104);
    check("ws_ir", IR, 32'hA5A5_0103);

    // Decode stall for five cycles.
    for (int i = 0; i < 5; i++) begin
      step();
      check("st_valid", {31'd0, IRValid}, 32'd1);
      check("st_ir", IR, 32'hA5A5_0103);
      check("st_memread", {31'd0, MemRead}, 32'd0);
      check("st_pc", PC, 32'h104);
    end
    IRAccept = 1'b1;
    step();
    IRAccept = 1'b0;
    check("st_cnt", FetchCount, 32'd4);
    check("st_resume", {31'd0, MemRead}, 32'd1);

    // Branch in FETCH racing MemReady: data dropped.
    Branch = 1'b1; BranchTarget = 32'h40; MemReady = 1'b1;
    #1;
    check("bf_pcwrite", {31'd0, PCWrite}, 32'd1);
    check("bf_pcinc", {31'd0, PCIncrement}, 32'd0);
    check("bf_pcd", PCD, 32'h40);
    step();
    Branch = 1'b0;
    check("bf_valid", {31'd0, IRValid}, 32'd0);
    check("bf_addr", MemAddr, 32'h40);
    check("bf_memread", {31'd0, MemRead}, 32'd1);
    check("bf_ir_kept", IR, 32'hA5A5_0103);
    step();
    MemReady = 1'b0;
    check("bf_ir_target", IR, 32'hA5A5_0040);

    // Branch in HOLD without accept: flush, count unchanged.
    Branch = 1'b1; BranchTarget = 32'h80;
    #1;
    check("bh_pcd", PCD, 32'h80);
    step();
    Branch = 1'b0;
    check("bh_valid", {31'd0, IRValid}, 32'd0);
    check("bh_cnt", FetchCount, 32'd4);
    check("bh_pc", PC, 32'h80);
    MemReady = 1'b1;
    step();
    MemReady = 1'b0;
    check("bh_ir", IR, 32'hA5A5_0080);

    // Branch in HOLD with accept: counts as accepted.
    Branch = 1'b1; IRAccept = 1'b1; BranchTarget = 32'h200;
    step();
    Branch = 1'b0; IRAccept = 1'b0;
    check("ba_cnt", FetchCount, 32'd5);
    check("ba_valid", {31'd0, IRValid}, 32'd0);
    check("ba_pc", PC, 32'h200);

    // Two more fetches to reach a count of 7, then park in HOLD.
    MemReady = 1'b1; IRAccept = 1'b1;
    step(); step(); step(); step();
    check("pre_cnt7", FetchCount, 32'd7);
    IRAccept = 1'b0;
    step();
    MemReady = 1'b0;
    check("pre_valid", {31'd0, IRValid}, 32'd1);
    check("pre_ir", IR, 32'hA5A5_0202);

    // Reset mid-operation from HOLD.
    Reset = 1'b1;
    #1;
    check("mr_pcwrite", {31'd0, PCWrite}, 32'd0);
    step();
    Reset = 1'b0;
    check("mr_valid", {31'd0, IRValid}, 32'd0);
    check("mr_ir", IR, 32'd0);
    check("mr_cnt", FetchCount, 32'd0);
    #1;
    check("mr_lv_pcwrite", {31'd0, PCWrite}, 32'd1);
    check("mr_lv_pcd", PCD, RV);
    step();
    check("mr_pc", PC, RV);
    check("mr_memread", {31'd0, MemRead}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
